pk_encode: RTL and testbench
============================

Name: pk_encode

Overview:
- Sequential ML-DSA public-key encoder: pk = rho || SimpleBitPack(t1[0], 1023) || ... || SimpleBitPack(t1[K-1], 1023).
- Accepts 32-byte rho plus a stream of t1 coefficients, emits the packed public key as a byte stream, byte 0 first.
- Sits on the keygen output path; its output is the exact byte image that the pk decoder unpacks on the verify side.

Parameters:
- K, 8, number of t1 polynomials; pk length = 32 + K*320 bytes (2592 at default).
- N, 256, coefficients per polynomial.
- COEFF_W, 10, bits per t1 coefficient, equal to bitlen(2^(bitlen(Q-1)-D)-1) with Q=8380417, D=13.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin encode; sampled only in IDLE.
- rho  in  256  seed; captured on accepted start; rho[7:0] is pk byte 0.
- coeff_valid  in  1  t1 coefficient valid.
- coeff  in  COEFF_W  t1 coefficient. Order is poly 0 coeff 0 .. poly K-1 coeff N-1.
- coeff_ready  out  1  coefficient accepted when coeff_valid && coeff_ready.
- pk_valid  out  1  pk_byte valid.
- pk_byte  out  8  packed output byte.
- pk_last  out  1  high with the final pk byte.
- pk_ready  in  1  downstream accepts byte when pk_valid && pk_ready.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the final byte is accepted.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; accumulator, bit count, byte counter and coeff counter cleared; rho register cleared. Reset mid-stream aborts the transfer with no further bytes. The encoder restarts only on a new start.
- States: IDLE -> RHO -> T1 -> DONE -> IDLE.
- IDLE:
  - start=1 latches rho and goes to RHO.
  - Latency: first byte valid the cycle after start.
  - start outside IDLE is ignored.
- RHO:
  - pk_valid=1, pk_byte = rho[8*i+7:8*i], i = byte counter 0..31.
  - i advances on each handshake.
  - Handshake at i=31 goes to T1.
  - coeff_ready=0.
- T1 packing, LSB-first SimpleBitPack:
  - 17-bit accumulator acc, 5-bit count cnt.
  - Coefficient accept: coeff_ready = (cnt<8) && (coeffs_accepted < K*N). On accept, acc |= coeff << cnt and cnt += COEFF_W.
  - Byte emit: pk_valid = (cnt>=8), pk_byte = acc[7:0]. On handshake, acc >>= 8 and cnt -= 8.
  - Accept and emit are mutually exclusive by construction, since coeff_ready requires cnt<8.
  - cnt never exceeds 17.
  - Every 4 coefficients produce exactly 5 bytes. cnt returns to 0 at each polynomial boundary because N*COEFF_W is a multiple of 8, so no padding bits are inserted.
- pk_last = pk_valid && (coeffs_accepted==K*N) && (cnt==8), i.e. byte index 32+K*320-1.
  - The handshake on that byte goes to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- Backpressure: while pk_valid && !pk_ready, pk_byte, pk_last and all internal state hold stable. pk_valid never deasserts without a handshake.
- Coefficient bits above COEFF_W do not exist, and no range checking is performed.
- coeff_valid while coeff_ready=0 is not consumed; the upstream must hold the value.
- Counters: 5-bit rho byte counter; coefficient counter wide enough for K*N (12 bits at default).

Test Plan:
- Reset, then start with rho=0x1F1E..0100 (byte i = i) and all coeffs 0 -> bytes 0x00..0x1F, then 2560 bytes of 0x00; pk_last only on byte 2591; done pulses one cycle later; busy then drops.
- First four coeffs 1,2,3,4, remaining 0 -> pk bytes 32..36 = 01 08 30 00 01.
- All coeffs 0x3FF -> every byte from 32 to 2591 is 0xFF; total handshakes = 2592; coeffs accepted = 2048.
- Random pk_ready and coeff_valid throttling with random coeffs -> output byte stream equals the software SimpleBitPack golden model; pk_byte stable whenever pk_valid && !pk_ready.
- rst_n pulsed low mid-T1 (e.g. after byte 1000) -> pk_valid and coeff_ready drop immediately; a subsequent start produces a full, correct 2592-byte pk from byte 0.
- start asserted again during RHO/T1 -> ignored; output is identical to the uninterrupted run.

Source files
------------

// File: rtl/pk_encode_if.sv
// Handshake bundle for the ML-DSA public-key encoder: control, rho seed,
// t1 coefficient input stream and packed pk byte output stream.
interface pk_encode_if #(
  parameter int COEFF_W = 10
);
  logic               start;
  logic [255:0]       rho;
  logic               coeff_valid;
  logic [COEFF_W-1:0] coeff;
  logic               coeff_ready;
  logic               pk_valid;
  logic [7:0]         pk_byte;
  logic               pk_last;
  logic               pk_ready;
  logic               busy;
  logic               done;

  modport master (
    output start, rho, coeff_valid, coeff, pk_ready,
    input  coeff_ready, pk_valid, pk_byte, pk_last, busy, done
  );

  modport slave (
    input  start, rho, coeff_valid, coeff, pk_ready,
    output coeff_ready, pk_valid, pk_byte, pk_last, busy, done
  );
endinterface

// File: rtl/pk_encode.sv
// ML-DSA public-key encoder: emits rho followed by the LSB-first
// SimpleBitPack of all t1 coefficients as a backpressured byte stream.
module pk_encode #(
  parameter int K       = 8,
  parameter int N       = 256,
  parameter int COEFF_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  pk_encode_if.slave  bus
);

  localparam int TOTAL = K * N;
  localparam int CC_W  = $clog2(TOTAL + 1);
  localparam int ACC_W = COEFF_W + 7;
  localparam int BC_W  = $clog2(ACC_W + 1);
  localparam logic [CC_W-1:0] TOTAL_COEFFS = CC_W'(TOTAL);

  typedef enum logic [1:0] {S_IDLE, S_RHO, S_T1, S_DONE} state_t;

  state_t            state, state_next;
  logic [255:0]      rho_q;
  logic [4:0]        byte_idx;
  logic [ACC_W-1:0]  acc;
  logic [BC_W-1:0]   cnt;
  logic [CC_W-1:0]   coeff_cnt;

  logic              pk_valid, pk_last, coeff_ready, busy, done;
  logic [7:0]        pk_byte;
  logic              byte_fire, coeff_fire;

  assign byte_fire  = pk_valid && bus.pk_ready;
  assign coeff_fire = coeff_ready && bus.coeff_valid;

  always_comb begin
    state_next  = state;
    pk_valid    = 1'b0;
    pk_byte     = 8'h00;
    pk_last     = 1'b0;
    coeff_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.start) state_next = S_RHO;
      end
      S_RHO: begin
        pk_valid = 1'b1;
        pk_byte  = rho_q[{byte_idx, 3'b000} +: 8];
        if (bus.pk_ready && byte_idx == 5'd31) state_next = S_T1;
      end
      S_T1: begin
        // Accept only while fewer than 8 bits are buffered, so accept and emit never collide
        coeff_ready = (cnt < BC_W'(8)) && (coeff_cnt < TOTAL_COEFFS);
        pk_valid    = (cnt >= BC_W'(8));
        pk_byte     = acc[7:0];
        pk_last     = pk_valid && (coeff_cnt == TOTAL_COEFFS) && (cnt == BC_W'(8));
        if (pk_last && bus.pk_ready) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rho_q     <= '0;
      byte_idx  <= '0;
      acc       <= '0;
      cnt       <= '0;
      coeff_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            rho_q     <= bus.rho;
            byte_idx  <= '0;
            acc       <= '0;
            cnt       <= '0;
            coeff_cnt <= '0;
          end
        end
        S_RHO: begin
          if (byte_fire) byte_idx <= byte_idx + 5'd1;
        end
        S_T1: begin
          if (coeff_fire) begin
            acc       <= acc | (ACC_W'(bus.coeff) << cnt);
            cnt       <= cnt + BC_W'(COEFF_W);
            coeff_cnt <= coeff_cnt + CC_W'(1);
          end else if (byte_fire) begin
            acc <= acc >> 8;
            cnt <= cnt - BC_W'(8);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pk_valid    = pk_valid;
  assign bus.pk_byte     = pk_byte;
  assign bus.pk_last     = pk_last;
  assign bus.coeff_ready = coeff_ready;
  assign bus.busy        = busy;
  assign bus.done        = done;

endmodule

// File: tb/tb_pk_encode.sv
// Directed/throttled bench for pk_encode against a bit-serial SimpleBitPack model.
module tb_pk_encode;

  localparam int K       = 8;
  localparam int N       = 256;
  localparam int COEFF_W = 10;
  localparam int TOTAL   = K * N;
  localparam int PK_LEN  = 32 + K * 320;
  localparam int BUDGET  = 30000;

  logic clk;
  logic rst_n;

  pk_encode_if #(.COEFF_W(COEFF_W)) bus ();

  pk_encode #(.K(K), .N(N), .COEFF_W(COEFF_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [255:0]       cur_rho;
  logic [COEFF_W-1:0] coeffs    [TOTAL];
  logic [7:0]         exp_bytes [PK_LEN];
  logic [7:0]         got       [PK_LEN];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Golden image built one bit at a time, independent of any accumulator scheme
  task automatic buildExpected();
    int bitpos;
    for (int i = 0; i < PK_LEN; i++) exp_bytes[i] = 8'h00;
    for (int i = 0; i < 32; i++) exp_bytes[i] = cur_rho[8*i +: 8];
    for (int c = 0; c < TOTAL; c++) begin
      for (int b = 0; b < COEFF_W; b++) begin
        bitpos = c * COEFF_W + b;
        exp_bytes[32 + bitpos / 8][bitpos % 8] = coeffs[c][b];
      end
    end
  endtask

  task automatic applyStimulus(input string name, input bit throttle, input bit inject_start, input int abort_at);
    int  out_idx, in_idx, cycles, early_done;
    bit  finished, held, coeff_pending;
    logic [7:0] held_byte;
    out_idx = 0; in_idx = 0; cycles = 0; early_done = 0;
    finished = 0; held = 0; coeff_pending = 0; held_byte = 8'h00;
    buildExpected();
    $display("[TB] run %s", name);

    @(posedge clk); #1;
    bus.start = 1'b1; bus.rho = cur_rho;
    bus.pk_ready = 1'b0; bus.coeff_valid = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.rho = ~cur_rho;

    while (!finished && cycles < BUDGET) begin
      bus.pk_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_idx < TOTAL) begin
        bus.coeff_valid = coeff_pending || !throttle || ($urandom_range(0, 2) != 0);
        bus.coeff       = bus.coeff_valid ? coeffs[in_idx] : COEFF_W'($urandom_range(0, 1023));
      end else begin
        bus.coeff_valid = 1'b0;
        bus.coeff       = '0;
      end
      bus.start = inject_start && (cycles == 8 || cycles == 600);
      bus.rho   = {8{32'($urandom())}};

      @(negedge clk);
      if (cycles == 0) checkOutput({name, " first_valid"}, 32'(bus.pk_valid), 32'd1);
      if (held) checkOutput({name, " hold"}, {23'd0, bus.pk_valid, bus.pk_byte}, {23'd0, 1'b1, held_byte});
      if (bus.done) early_done++;
      if (bus.pk_valid && bus.pk_ready) begin
        checkOutput($sformatf("%s byte%0d", name, out_idx), 32'(bus.pk_byte), 32'(exp_bytes[out_idx]));
        checkOutput($sformatf("%s last%0d", name, out_idx), 32'(bus.pk_last), 32'(out_idx == PK_LEN - 1));
        got[out_idx] = bus.pk_byte;
        out_idx++;
        if (out_idx == PK_LEN) finished = 1;
      end
      held      = bus.pk_valid && !bus.pk_ready;
      held_byte = bus.pk_byte;
      coeff_pending = bus.coeff_valid && !bus.coeff_ready;
      if (bus.coeff_valid && bus.coeff_ready) in_idx++;

      if (abort_at >= 0 && out_idx == abort_at) begin
        @(posedge clk); #1;
        rst_n = 1'b0; bus.start = 1'b0; bus.coeff_valid = 1'b0;
        #1;
        checkOutput({name, " abort pk_valid"}, 32'(bus.pk_valid), 32'd0);
        checkOutput({name, " abort coeff_ready"}, 32'(bus.coeff_ready), 32'd0);
        checkOutput({name, " abort busy"}, 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput({name, " post-abort idle"}, 32'(bus.pk_valid), 32'd0);
        return;
      end
      @(posedge clk); #1;
      cycles++;
    end

    if (!finished) begin
      checkOutput({name, " timeout bytes"}, 32'(out_idx), 32'(PK_LEN));
      return;
    end
    // The final handshake edge was just taken by the loop exit
    bus.start = 1'b0; bus.pk_ready = 1'b0; bus.coeff_valid = 1'b0;
    @(negedge clk);
    checkOutput({name, " done pulse"}, 32'(bus.done), 32'd1);
    checkOutput({name, " busy in done"}, 32'(bus.busy), 32'd1);
    checkOutput({name, " no valid in done"}, 32'(bus.pk_valid), 32'd0);
    @(negedge clk);
    checkOutput({name, " done dropped"}, 32'(bus.done), 32'd0);
    checkOutput({name, " busy dropped"}, 32'(bus.busy), 32'd0);
    checkOutput({name, " coeffs accepted"}, 32'(in_idx), 32'(TOTAL));
    checkOutput({name, " early done"}, 32'(early_done), 32'd0);
  endtask

  task automatic randomData();
    cur_rho = {8{32'($urandom())}};
    for (int c = 0; c < TOTAL; c++) coeffs[c] = COEFF_W'($urandom_range(0, 1023));
  endtask

  initial begin
    logic [7:0] lit [5];
    lit = '{8'h01, 8'h08, 8'h30, 8'h00, 8'h01};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.rho = '0; bus.coeff_valid = 1'b0; bus.coeff = '0; bus.pk_ready = 1'b0;
    #12;
    checkOutput("reset pk_valid", 32'(bus.pk_valid), 32'd0);
    checkOutput("reset coeff_ready", 32'(bus.coeff_ready), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset pk_last", 32'(bus.pk_last), 32'd0);
    checkOutput("reset pk_byte", 32'(bus.pk_byte), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // rho byte i = i, all coefficients zero
    for (int i = 0; i < 32; i++) cur_rho[8*i +: 8] = 8'(i);
    for (int c = 0; c < TOTAL; c++) coeffs[c] = '0;
    applyStimulus("zeros", 1'b0, 1'b0, -1);
    checkOutput("zeros rho byte5", 32'(got[5]), 32'h05);
    checkOutput("zeros rho byte31", 32'(got[31]), 32'h1F);
    checkOutput("zeros t1 byte2591", 32'(got[PK_LEN-1]), 32'h00);

    // First four coefficients 1,2,3,4 pack to 01 08 30 00 01
    coeffs[0] = 10'd1; coeffs[1] = 10'd2; coeffs[2] = 10'd3; coeffs[3] = 10'd4;
    applyStimulus("small", 1'b0, 1'b0, -1);
    for (int i = 0; i < 5; i++) checkOutput($sformatf("small hand byte%0d", 32 + i), 32'(got[32 + i]), 32'(lit[i]));

    for (int c = 0; c < TOTAL; c++) coeffs[c] = 10'h3FF;
    applyStimulus("ones", 1'b0, 1'b0, -1);
    checkOutput("ones byte32", 32'(got[32]), 32'hFF);
    checkOutput("ones byte2591", 32'(got[PK_LEN-1]), 32'hFF);

    randomData();
    applyStimulus("throttled", 1'b1, 1'b0, -1);

    randomData();
    applyStimulus("aborted", 1'b1, 1'b0, 1000);
    randomData();
    applyStimulus("after abort", 1'b1, 1'b0, -1);

    randomData();
    applyStimulus("restart ignored", 1'b1, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
